// File: rtl/ar429_pkg.sv
// Shared types and constants for the ARINC-429-style receiver slice.
package ar429_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        RECV = 2'd2
    } ar_state_e;

    localparam int ERR_PAR       = 0;
    localparam int ERR_RAIL      = 1;
    localparam int LABEL_BITS    = 8;
    localparam int DEF_WORD_BITS = 32;

endpackage

// File: rtl/ar_rx_sync.sv
// Per-rail input synchroniser with activity, rise and fall detection on the combined line.
module ar_rx_sync #(
    parameter int SYNC_STAGES = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic inp0,
    input  logic inp1,
    output logic s0_o,
    output logic s1_o,
    output logic act_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r0_q;
    logic [SYNC_STAGES-1:0] r1_q;
    logic                   act_dly_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q      <= '0;
            r1_q      <= '0;
            act_dly_q <= 1'b0;
        end else begin
            r0_q      <= {r0_q[SYNC_STAGES-2:0], inp0};
            r1_q      <= {r1_q[SYNC_STAGES-2:0], inp1};
            act_dly_q <= act_o;
        end
    end

    assign s0_o   = r0_q[SYNC_STAGES-1];
    assign s1_o   = r1_q[SYNC_STAGES-1];
    assign act_o  = s0_o | s1_o;
    assign rise_o = act_o & ~act_dly_q;
    assign fall_o = ~act_o & act_dly_q;

endmodule

// File: rtl/ar_rxd_sync.sv
// Synchronous bipolar RZ word receiver: rate measurement, gap framing, parity/rail checks, holding register.
// Optional label filter enabled by defining AR_RXD_LABEL_FILTER_EN.
module ar_rxd_sync
    import ar429_pkg::*;
#(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 24,
    parameter int GAP_SHIFT   = 2,
    parameter int INIT_HBIT   = 50
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inp0,
    input  logic                  inp1,
`ifdef AR_RXD_LABEL_FILTER_EN
    input  logic [255:0]          i_lbl_en,
`endif
    output logic [LABEL_BITS-1:0] o_label,
    output logic [WORD_BITS-10:0] o_data,
    output logic [1:0]            o_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_frm_err,
    output logic                  o_ovr,
    output logic [CNT_W-1:0]      o_hbit
);

    localparam int DATA_W = WORD_BITS - 9;
    localparam int BC_W   = $clog2(WORD_BITS + 3);
    localparam logic [BC_W-1:0] BC_LBL  = BC_W'(LABEL_BITS);
    localparam logic [BC_W-1:0] BC_DATA = BC_W'(WORD_BITS - 1);
    localparam logic [BC_W-1:0] BC_WORD = BC_W'(WORD_BITS);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(WORD_BITS + 1);

    logic s0, s1, act, rise, fall;

    ar_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .inp0   (inp0),
        .inp1   (inp1),
        .s0_o   (s0),
        .s1_o   (s1),
        .act_o  (act),
        .rise_o (rise),
        .fall_o (fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] hi_cnt_q, hbit_q, gap_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d, gap_cnt_d, gap_thr;
    logic             gap_hit;

    assign hi_cnt_d  = act ? sat_inc(hi_cnt_q) : CNT_W'(1);
    assign gap_cnt_d = act ? '0 : sat_inc(gap_cnt_q);
    assign gap_thr   = hbit_q << GAP_SHIFT;
    // A saturated gap counter must not re-fire every clock.
    assign gap_hit   = (gap_cnt_q == gap_thr) && !(&gap_cnt_q);

    // hi_cnt has already stepped once past the last high clock when fall is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_q  <= CNT_W'(1);
            hbit_q    <= CNT_W'(INIT_HBIT);
            gap_cnt_q <= '0;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            if (fall) hbit_q <= hi_cnt_q - CNT_W'(1);
        end
    end

    ar_state_e state_q, state_d;
    logic [BC_W-1:0] bit_cnt_q;
    logic take_first, take_next, word_end, finish, frm_set;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (gap_hit) state_d = IDLE;
            IDLE:    if (rise)    state_d = RECV;
            RECV:    if (gap_hit) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        take_first = 1'b0;
        take_next  = 1'b0;
        word_end   = 1'b0;
        case (state_q)
            IDLE:    take_first = rise;
            RECV: begin
                word_end  = gap_hit;
                take_next = rise & ~gap_hit;
            end
            default: ;
        endcase
    end

    assign finish  = word_end & (bit_cnt_q == BC_WORD);
    assign frm_set = word_end & (bit_cnt_q != BC_WORD);

    logic [BC_W-1:0]       bit_n;
    logic [LABEL_BITS-1:0] label_q;
    logic [DATA_W-1:0]     data_q;
    logic                  par_q, rail_q;

    assign bit_n = take_first ? BC_W'(1) : bit_cnt_q + BC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            label_q   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            rail_q    <= 1'b0;
        end else if (take_first || take_next) begin
            if (take_first) begin
                bit_cnt_q <= BC_W'(1);
                rail_q    <= s1 & s0;
            end else begin
                if (bit_cnt_q != BC_SAT) bit_cnt_q <= bit_cnt_q + BC_W'(1);
                rail_q <= rail_q | (s1 & s0);
            end
            if (bit_n <= BC_LBL)       label_q <= {label_q[LABEL_BITS-2:0], s1};
            else if (bit_n <= BC_DATA) data_q  <= {s1, data_q[DATA_W-1:1]};
            else if (bit_n == BC_WORD) par_q   <= s1;
        end
    end

    logic       lbl_pass, load, drop;
    logic [1:0] word_err;

`ifdef AR_RXD_LABEL_FILTER_EN
    assign lbl_pass = i_lbl_en[label_q];
`else
    assign lbl_pass = 1'b1;
`endif

    always_comb begin
        word_err           = '0;
        word_err[ERR_RAIL] = rail_q;
        word_err[ERR_PAR]  = ~^{label_q, data_q, par_q};
    end

    assign load = finish & lbl_pass & (~o_valid | i_ready);
    assign drop = finish & lbl_pass & o_valid & ~i_ready;

    logic [LABEL_BITS-1:0] hold_label_q;
    logic [DATA_W-1:0]     hold_data_q;
    logic [1:0]            hold_err_q;
    logic                  valid_q, frm_q, ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_label_q <= '0;
            hold_data_q  <= '0;
            hold_err_q   <= '0;
            valid_q      <= 1'b0;
            frm_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            frm_q <= frm_set;
            if (load) begin
                hold_label_q <= label_q;
                hold_data_q  <= data_q;
                hold_err_q   <= word_err;
                valid_q      <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
            if (drop) ovr_q <= 1'b1;
        end
    end

    assign o_label   = hold_label_q;
    assign o_data    = hold_data_q;
    assign o_err     = hold_err_q;
    assign o_valid   = valid_q;
    assign o_frm_err = frm_q;
    assign o_ovr     = ovr_q;
    assign o_hbit    = hbit_q;

endmodule

// File: tb/tb_ar_rxd_sync.sv
// Self-checking bench for ar_rxd_sync: line-level transmitter model and word-level reference.
module tb_ar_rxd_sync;

    localparam int WB = 32;
    localparam int DW = WB - 9;
    localparam int H0 = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, inp0, inp1, i_ready;
    logic [7:0]    o_label;
    logic [DW-1:0] o_data;
    logic [1:0]    o_err;
    logic          o_valid, o_frm_err, o_ovr;
    logic [23:0]   o_hbit;
`ifdef AR_RXD_LABEL_FILTER_EN
    logic [255:0]  i_lbl_en = '1;
`endif

    ar_rxd_sync #(
        .WORD_BITS(WB), .SYNC_STAGES(2), .CNT_W(24), .GAP_SHIFT(2), .INIT_HBIT(H0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp0      (inp0),
        .inp1      (inp1),
`ifdef AR_RXD_LABEL_FILTER_EN
        .i_lbl_en  (i_lbl_en),
`endif
        .o_label   (o_label),
        .o_data    (o_data),
        .o_err     (o_err),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_frm_err (o_frm_err),
        .o_ovr     (o_ovr),
        .o_hbit    (o_hbit)
    );

    typedef struct packed {
        logic [7:0]    label;
        logic [DW-1:0] data;
        logic [1:0]    err;
    } word_t;

    word_t got_q[$];
    int    frm_cnt = 0;
    int    checks  = 0;
    int    errors  = 0;

    // Consumer side: record every accepted word and every framing pulse.
    always @(negedge clk) begin
        if (o_valid && i_ready) got_q.push_back({o_label, o_data, o_err});
        if (o_frm_err) frm_cnt++;
    end

    // Word image in transmission order: frame[WB-1] goes out first.
    function automatic logic [WB-1:0] make_frame(input logic [7:0] lbl, input logic [DW-1:0] dat,
                                                 input logic flip);
        logic [WB-1:0] f;
        f = '0;
        f[WB-1 -: 8] = lbl;
        for (int k = 0; k < DW; k++) f[WB-9-k] = dat[k];
        f[0] = (~^{lbl, dat}) ^ flip;
        return f;
    endfunction

    function automatic word_t model(input logic [WB-1:0] f, input logic rail);
        word_t w;
        w.label = f[WB-1 -: 8];
        for (int k = 0; k < DW; k++) w.data[k] = f[WB-9-k];
        w.err[1] = rail;
        w.err[0] = ($countones(f) % 2) == 0;
        return w;
    endfunction

    task automatic drive(input logic r1, input logic r0, input int n);
        inp1 = r1;
        inp0 = r0;
        repeat (n) @(negedge clk);
    endtask

    // Bits past WB are sent as ones; fault drives both rails; rst_at pulses reset in that bit's low half.
    task automatic send_bits(input logic [WB-1:0] f, input int nbits, input int h,
                             input int fault, input int rst_at);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = (i < WB) ? f[WB-1-i] : 1'b1;
            if (i == fault) drive(1'b1, 1'b1, h);
            else            drive(b, ~b, h);
            if (i == rst_at) begin
                drive(1'b0, 1'b0, 4);
                rst = 1'b1;
                drive(1'b0, 1'b0, 2);
                rst = 1'b0;
                drive(1'b0, 1'b0, h - 6);
            end else begin
                drive(1'b0, 1'b0, h);
            end
        end
    endtask

    task automatic wait_word(output bit ok, output word_t w);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (got_q.size() > 0) begin
                w  = got_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inp0 = 1'b0; inp1 = 1'b0; i_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({o_valid, o_frm_err, o_ovr, o_err, o_label, o_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v%0b f%0b o%0b e%0b l%h d%h want all 0",
                     o_valid, o_frm_err, o_ovr, o_err, o_label, o_data);
        end
        checks++;
        if (o_hbit !== 24'(H0)) begin
            errors++; $display("FAIL reset_hbit got %0d want %0d", o_hbit, H0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1000);
    endtask

    task automatic test_basic();
        logic [WB-1:0] f;
        word_t exp, w;
        bit ok;
        f   = make_frame(8'h5A, 23'h12345, 1'b0);
        exp = model(f, 1'b0);
        send_bits(f, WB, H0, -1, -1);
        // Two sync clocks plus the 4*hbit idle count, then one clock to load.
        repeat (4*H0 + 2 - H0) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", o_valid); end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency got %0b want 1", o_valid); end
        wait_word(ok, w);
        checks++;
        if (!ok || w !== exp) begin
            errors++; $display("FAIL basic_word got %h (ok %0b) want %h", w, ok, exp);
        end
        checks++;
        if (o_hbit !== 24'(H0)) begin errors++; $display("FAIL basic_hbit got %0d want %0d", o_hbit, H0); end
    endtask

    task automatic test_parity();
        logic [WB-1:0] f;
        word_t w;
        bit ok;
        f = make_frame(8'h5A, 23'h12345, 1'b1);
        send_bits(f, WB, H0, -1, -1);
        drive(1'b0, 1'b0, 4*H0 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w.err !== 2'b01 || w.label !== 8'h5A || w.data !== 23'h12345) begin
            errors++; $display("FAIL parity_word got %h (ok %0b) want label 5a data 12345 err 01", w, ok);
        end
    endtask

    task automatic test_hbit_switch();
        logic [WB-1:0] f;
        word_t w;
        bit ok;
        f = make_frame(8'hC3, 23'h7F00F, 1'b0);
        send_bits(f, WB, H0, -1, -1);
        drive(1'b0, 1'b0, 4*H0 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w !== model(f, 1'b0)) begin errors++; $display("FAIL hbit50_word got %h want %h", w, model(f, 1'b0)); end
        f = make_frame(8'h21, 23'h0ABCD, 1'b0);
        send_bits(f, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w !== model(f, 1'b0)) begin errors++; $display("FAIL hbit20_word got %h want %h", w, model(f, 1'b0)); end
        checks++;
        if (o_hbit !== 24'd20) begin errors++; $display("FAIL hbit20_value got %0d want 20", o_hbit); end
    endtask

    task automatic test_random();
        logic [WB-1:0] f, rx;
        logic [7:0]    lbl;
        logic [DW-1:0] dat;
        word_t w, exp;
        bit ok;
        int h, fault;
        for (int n = 0; n < 6; n++) begin
            lbl   = 8'($urandom);
            dat   = DW'($urandom);
            h     = int'($urandom_range(6, 20));
            fault = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WB-1)) : -1;
            f     = make_frame(lbl, dat, 1'($urandom_range(0, 1)));
            rx    = f;
            if (fault >= 0) rx[WB-1-fault] = 1'b1;
            exp   = model(rx, fault >= 0);
            send_bits(f, WB, h, fault, -1);
            drive(1'b0, 1'b0, 4*h + 10);
            wait_word(ok, w);
            checks++;
            if (!ok || w !== exp) begin
                errors++; $display("FAIL random_word[%0d] got %h (ok %0b) want %h h=%0d fault=%0d", n, w, ok, exp, h, fault);
            end
            checks++;
            if (o_hbit !== 24'(h)) begin errors++; $display("FAIL random_hbit[%0d] got %0d want %0d", n, o_hbit, h); end
        end
    endtask

    task automatic test_frame_err();
        logic [WB-1:0] f;
        word_t w;
        bit ok;
        int base;
        base = frm_cnt;
        f = make_frame(8'h99, 23'h55555, 1'b0);
        send_bits(f, WB - 1, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (frm_cnt - base !== 1) begin errors++; $display("FAIL frm_short_pulses got %0d want 1", frm_cnt - base); end
        checks++;
        if (got_q.size() != 0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL frm_short_no_word got q%0d v%0b want q0 v0", got_q.size(), o_valid);
        end
        send_bits(f, WB + 1, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (frm_cnt - base !== 2 || got_q.size() != 0) begin
            errors++; $display("FAIL frm_long got pulses %0d q%0d want 2 q0", frm_cnt - base, got_q.size());
        end
        send_bits(f, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w !== model(f, 1'b0) || frm_cnt - base !== 2) begin
            errors++; $display("FAIL frm_recover got %h (ok %0b) pulses %0d want %h pulses 2", w, ok, frm_cnt - base, model(f, 1'b0));
        end
    endtask

`ifdef AR_RXD_LABEL_FILTER_EN
    task automatic test_label_filter();
        logic [WB-1:0] f;
        word_t w;
        bit ok;
        i_lbl_en[8'h5A] = 1'b0;
        f = make_frame(8'h5A, 23'h12345, 1'b0);
        send_bits(f, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (got_q.size() != 0 || o_valid !== 1'b0 || o_ovr !== 1'b0) begin
            errors++; $display("FAIL filter_drop got q%0d v%0b ovr%0b want q0 v0 ovr0", got_q.size(), o_valid, o_ovr);
        end
        f = make_frame(8'h33, 23'h12345, 1'b0);
        send_bits(f, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w !== model(f, 1'b0)) begin errors++; $display("FAIL filter_pass got %h want %h", w, model(f, 1'b0)); end
        i_lbl_en = '1;
    endtask
`endif

    task automatic test_overrun();
        logic [WB-1:0] fa, fb;
        word_t w, exp_a;
        bit ok, stable;
        fa = make_frame(8'h0F, 23'h01234, 1'b0);
        fb = make_frame(8'hF0, 23'h43210, 1'b1);
        exp_a = model(fa, 1'b0);
        i_ready = 1'b0;
        send_bits(fa, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (o_valid !== 1'b1 || o_ovr !== 1'b0) begin
            errors++; $display("FAIL ovr_first_held got v%0b ovr%0b want v1 ovr0", o_valid, o_ovr);
        end
        send_bits(fb, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", o_ovr); end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_valid !== 1'b1 || {o_label, o_data, o_err} !== exp_a) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL ovr_hold_stable got %h v%0b want %h v1", {o_label, o_data, o_err}, o_valid, exp_a); end
        i_ready = 1'b1;
        wait_word(ok, w);
        checks++;
        if (!ok || w !== exp_a) begin errors++; $display("FAIL ovr_first_word got %h want %h", w, exp_a); end
        repeat (30) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || o_valid !== 1'b0 || o_ovr !== 1'b1) begin
            errors++; $display("FAIL ovr_second_dropped got q%0d v%0b ovr%0b want q0 v0 ovr1", got_q.size(), o_valid, o_ovr);
        end
    endtask

    task automatic test_reset_midword();
        logic [WB-1:0] f1, f2, f3;
        word_t w;
        bit ok;
        int base;
        f1 = make_frame(8'h77, 23'h11111, 1'b0);
        f2 = make_frame(8'h88, 23'h22222, 1'b0);
        f3 = make_frame(8'h3C, 23'h6A5A5, 1'b0);
        send_bits(f1, WB, 20, -1, 11);
        base = frm_cnt;
        send_bits(f2, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        checks++;
        if (got_q.size() != 0 || o_valid !== 1'b0 || o_ovr !== 1'b0 || frm_cnt != base) begin
            errors++; $display("FAIL rst_mid_silent got q%0d v%0b ovr%0b pulses %0d want q0 v0 ovr0 pulses 0",
                               got_q.size(), o_valid, o_ovr, frm_cnt - base);
        end
        send_bits(f3, WB, 20, -1, -1);
        drive(1'b0, 1'b0, 4*20 + 10);
        wait_word(ok, w);
        checks++;
        if (!ok || w !== model(f3, 1'b0)) begin errors++; $display("FAIL rst_mid_next got %h (ok %0b) want %h", w, ok, model(f3, 1'b0)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_hbit_switch();
        test_random();
        test_frame_err();
`ifdef AR_RXD_LABEL_FILTER_EN
        test_label_filter();
`endif
        test_overrun();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
